iob_cache_back_end_arb: RTL and testbench
=========================================

Name: iob_cache_back_end_arb

Overview:
Next-generation cache back-end controller. It arbitrates a single back-end memory port between the write-through buffer (single-beat writes) and the line-replacement reader (bursts of 2**LINE2BE_W beats). Unlike the previous back-end, it does not rely on the two requesters being mutually exclusive:
- grants are explicit and locked for a whole burst;
- read-after-write hazards on the replaced line are ordered in hardware;
- starvation of either side is bounded.
It sits between the cache core and the back-end memory/interconnect.

Parameters:
BE_ADDR_W, 32, back-end byte-address width
BE_DATA_W, 32, back-end data width (multiple of 8); BE_NBYTES=BE_DATA_W/8, BE_NBYTES_W=log2(BE_NBYTES)
LINE2BE_W, 2, log2 of back-end beats per cache line (0 means one-beat lines)
WRITE_FIRST, 1, 1: writes win simultaneous requests; 0: replacement wins
STARVE_W, 3, width of the consecutive-grant counter; limit = 2**STARVE_W-1

Ports:
clk_i  in  1  clock
reset  in  1  reset
write_valid  in  1  write request; held stable until write_ready
write_addr  in  BE_ADDR_W  write byte address
write_wdata  in  BE_DATA_W  write data
write_wstrb  in  BE_NBYTES  byte enables (nonzero)
write_ready  out  1  one-cycle pulse: write completed at back-end
replace_valid  in  1  line-fill request; held until burst done
replace_addr  in  BE_ADDR_W-BE_NBYTES_W-LINE2BE_W  line address
replace  out  1  high from read grant through last beat
read_valid  out  1  beat strobe into line buffer
read_addr  out  max(LINE2BE_W,1)  beat index within line
read_rdata  out  BE_DATA_W  beat data
be_valid  out  1  back-end request
be_addr  out  BE_ADDR_W  back-end byte address
be_wdata  out  BE_DATA_W  back-end write data
be_wstrb  out  BE_NBYTES  back-end strobes; 0 means read
be_rdata  in  BE_DATA_W  back-end read data
be_ready  in  1  back-end beat accept/complete

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs are 0, state is IDLE, beat counter 0, starve counter 0. Reset mid-burst or mid-write abandons the transaction; the requester re-issues.
- States:
  - IDLE: be_valid=0. Grant decision is registered, so the first be_valid comes 1 cycle after the request.
  - WR: be_valid=1; be_addr=write_addr; be_wdata=write_wdata; be_wstrb=write_wstrb. On be_ready: write_ready=1 in the same cycle, then to IDLE.
  - RD: be_valid=1; be_addr={replace_addr, beat, BE_NBYTES_W zeros}; be_wstrb=0; replace=1. On each be_ready: read_valid=1, read_addr=beat, read_rdata=be_rdata (all combinational, same cycle), then beat++. On the last beat (beat=2**LINE2BE_W-1) with be_ready: to IDLE and beat=0.
- Outputs are stable while be_valid=1 and be_ready=0. be_ready outside WR/RD is ignored.
- Arbitration in IDLE, highest priority first:
  1. Hazard: write_valid && replace_valid && write_addr line bits == replace_addr -> WR. Pending write to the line being filled always drains first.
  2. Starvation: starve counter at limit -> grant the side that lost last time.
  3. Both valid -> WRITE_FIRST selects WR or RD.
  4. Single valid -> that side.
- Starve counter:
  - +1 (saturating) on each grant while the other side was valid and lost.
  - Cleared on a grant to the side that had been losing.
  - Cleared when no contention.
- One back-to-back turnaround: after WR/RD completion the block spends ≥1 cycle in IDLE.
- With LINE2BE_W=0, RD is a single beat; read_addr is tied to 0.

Decomposition:
- Package iob_cache_back_end_arb_pkg:
  - state encoding (IDLE=0, WR=1, RD=2);
  - BE_NBYTES/BE_NBYTES_W and line-address slicing functions.
- One sub-module, iob_cache_be_arbiter: combinational priority plus starve counter. It takes both valids, the hazard flag and a done pulse, and outputs the grant.
- The FSM, beat counter and muxing stay in the top module.

Test Plan:
- Lone write to 0x0000_0104, wstrb=0xF, be_ready after 2 cycles -> one be_valid phase with be_addr=0x104 and be_wstrb=0xF; write_ready pulses exactly once, in the be_ready cycle.
- Lone replace of line 0x10 (LINE2BE_W=2, 32-bit), be_ready every cycle -> be_addr 0x100, 0x104, 0x108, 0x10C; read_addr 0..3; read_valid 4 cycles; replace high 4 cycles; be_wstrb=0.
- Simultaneous write to 0x108 and replace of line 0x10, WRITE_FIRST=0 -> hazard forces WR first; RD burst starts after 1 IDLE cycle.
- WRITE_FIRST=1, write_valid held continuously (new writes) with replace_valid pending, STARVE_W=3 -> exactly 7 writes granted, then the RD burst.
- Reset asserted on beat 2 of a burst -> next cycle all outputs 0, beat=0; re-issued replace restarts at beat 0.
- be_ready stalled 5 cycles mid-burst -> be_addr, be_valid and read_addr stable; no read_valid during the stall.

Source files
------------

// File: rtl/iob_cache_back_end_arb_pkg.sv
// iob_cache_back_end_arb_pkg
// Shared definitions for the cache back-end arbiter:
//   - FSM state encoding (IDLE=0, WR=1, RD=2)
//   - back-end byte/beat geometry helpers
//   - line-address extraction from a byte address
package iob_cache_back_end_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RD   = 2'd2
   } state_t;

   function automatic int be_nbytes(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int be_nbytes_w(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   // Beat index is at least one bit wide so one-beat lines still have a port.
   function automatic int beat_w(input int line2be_w);
      return (line2be_w > 0) ? line2be_w : 1;
   endfunction

   // Line address of a byte address: drop the byte-in-beat and beat-in-line bits.
   function automatic logic [63:0] line_of(input logic [63:0] addr, input int unsigned lsb);
      return addr >> lsb;
   endfunction

endpackage

// File: rtl/iob_cache_back_end_arb_if.sv
// iob_cache_back_end_arb_if
// Bundles the write-buffer, replacement-reader and back-end memory signals.
//   slave  : the arbiter (consumes requests, drives the back-end request)
//   master : the surrounding cache core / memory model
interface iob_cache_back_end_arb_if
   import iob_cache_back_end_arb_pkg::*;
#(
   parameter int BE_ADDR_W = 32,
   parameter int BE_DATA_W = 32,
   parameter int LINE2BE_W = 2
);
   localparam int BE_NBYTES   = be_nbytes(BE_DATA_W);
   localparam int BE_NBYTES_W = be_nbytes_w(BE_DATA_W);
   localparam int LINE_W      = BE_ADDR_W - BE_NBYTES_W - LINE2BE_W;
   localparam int BEAT_W      = beat_w(LINE2BE_W);

   logic                 write_valid;
   logic [BE_ADDR_W-1:0] write_addr;
   logic [BE_DATA_W-1:0] write_wdata;
   logic [BE_NBYTES-1:0] write_wstrb;
   logic                 write_ready;

   logic                 replace_valid;
   logic [LINE_W-1:0]    replace_addr;
   logic                 replace;
   logic                 read_valid;
   logic [BEAT_W-1:0]    read_addr;
   logic [BE_DATA_W-1:0] read_rdata;

   logic                 be_valid;
   logic [BE_ADDR_W-1:0] be_addr;
   logic [BE_DATA_W-1:0] be_wdata;
   logic [BE_NBYTES-1:0] be_wstrb;
   logic [BE_DATA_W-1:0] be_rdata;
   logic                 be_ready;

   modport slave (
      input  write_valid, write_addr, write_wdata, write_wstrb,
      input  replace_valid, replace_addr,
      input  be_rdata, be_ready,
      output write_ready, replace, read_valid, read_addr, read_rdata,
      output be_valid, be_addr, be_wdata, be_wstrb
   );

   modport master (
      output write_valid, write_addr, write_wdata, write_wstrb,
      output replace_valid, replace_addr,
      output be_rdata, be_ready,
      input  write_ready, replace, read_valid, read_addr, read_rdata,
      input  be_valid, be_addr, be_wdata, be_wstrb
   );
endinterface

// File: rtl/iob_cache_be_arbiter.sv
// iob_cache_be_arbiter
// Priority arbiter with bounded starvation between the write buffer and the
// line-replacement reader.
//   clk_i, reset    : clock, synchronous active-high reset
//   arb_en          : high while the back-end port is free (grant is taken)
//   write_valid     : write buffer request
//   replace_valid   : replacement request
//   hazard          : pending write targets the line being replaced
//   grant_wr/rd     : one-hot grant, only meaningful while arb_en is high
module iob_cache_be_arbiter #(
   parameter int WRITE_FIRST = 1,
   parameter int STARVE_W    = 3
) (
   input  logic clk_i,
   input  logic reset,
   input  logic arb_en,
   input  logic write_valid,
   input  logic replace_valid,
   input  logic hazard,
   output logic grant_wr,
   output logic grant_rd
);
   localparam logic [STARVE_W-1:0] LIMIT = '1;

   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                loser_wr_q, loser_wr_d;  // 1: write side lost the last contended grant
   logic                contend;

   assign contend = write_valid && replace_valid;

   always_comb begin
      grant_wr   = 1'b0;
      grant_rd   = 1'b0;
      starve_d   = starve_q;
      loser_wr_d = loser_wr_q;
      if (arb_en) begin
         if (contend) begin
            // A write to the line being filled must land before the fill reads it.
            if (hazard)
               grant_wr = 1'b1;
            else if (starve_q == LIMIT)
               grant_wr = loser_wr_q;
            else
               grant_wr = (WRITE_FIRST != 0);
            grant_rd = !grant_wr;
            // Serving the side that had been losing resets the streak; anything
            // else extends it. A zero count has no streak to break.
            if (starve_q != '0 && grant_wr == loser_wr_q)
               starve_d = '0;
            else if (starve_q != LIMIT)
               starve_d = starve_q + 1'b1;
            loser_wr_d = !grant_wr;
         end else if (write_valid) begin
            grant_wr = 1'b1;
            starve_d = '0;
         end else if (replace_valid) begin
            grant_rd = 1'b1;
            starve_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         starve_q   <= '0;
         loser_wr_q <= 1'b0;
      end else begin
         starve_q   <= starve_d;
         loser_wr_q <= loser_wr_d;
      end
   end
endmodule

// File: rtl/iob_cache_back_end_arb.sv
// iob_cache_back_end_arb
// Shares one back-end memory port between single-beat write-through writes and
// multi-beat line-replacement reads. Grants are registered and locked for a
// whole transaction; each transaction is followed by at least one IDLE cycle.
//   clk_i  : clock
//   reset  : synchronous active-high reset; abandons any transaction in flight
//   bus    : write, replacement and back-end signals (slave side)
module iob_cache_back_end_arb
   import iob_cache_back_end_arb_pkg::*;
#(
   parameter int BE_ADDR_W   = 32,
   parameter int BE_DATA_W   = 32,
   parameter int LINE2BE_W   = 2,
   parameter int WRITE_FIRST = 1,
   parameter int STARVE_W    = 3
) (
   input  logic                    clk_i,
   input  logic                    reset,
   iob_cache_back_end_arb_if.slave bus
);
   localparam int BE_NBYTES_W = be_nbytes_w(BE_DATA_W);
   localparam int LINE_LSB    = BE_NBYTES_W + LINE2BE_W;
   localparam int BEAT_W      = beat_w(LINE2BE_W);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'((1 << LINE2BE_W) - 1);

   state_t              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic                hazard;
   logic                grant_wr, grant_rd;
   logic [BE_ADDR_W-1:0] rd_addr;

   assign hazard = bus.write_valid && bus.replace_valid &&
                   (line_of(64'(bus.write_addr), LINE_LSB) == 64'(bus.replace_addr));

   // {replace_addr, beat, byte-offset zeros}
   assign rd_addr = BE_ADDR_W'((64'(bus.replace_addr) << LINE_LSB) |
                               (64'(beat_q) << BE_NBYTES_W));

   iob_cache_be_arbiter #(
      .WRITE_FIRST (WRITE_FIRST),
      .STARVE_W    (STARVE_W)
   ) u_arbiter (
      .clk_i         (clk_i),
      .reset         (reset),
      .arb_en        (state_q == S_IDLE),
      .write_valid   (bus.write_valid),
      .replace_valid (bus.replace_valid),
      .hazard        (hazard),
      .grant_wr      (grant_wr),
      .grant_rd      (grant_rd)
   );

   always_comb begin
      state_d         = state_q;
      beat_d          = beat_q;
      bus.be_valid    = 1'b0;
      bus.be_addr     = '0;
      bus.be_wdata    = '0;
      bus.be_wstrb    = '0;
      bus.write_ready = 1'b0;
      bus.replace     = 1'b0;
      bus.read_valid  = 1'b0;
      bus.read_addr   = '0;
      bus.read_rdata  = '0;
      case (state_q)
         S_IDLE: begin
            if (grant_wr)      state_d = S_WR;
            else if (grant_rd) state_d = S_RD;
         end
         S_WR: begin
            bus.be_valid = 1'b1;
            bus.be_addr  = bus.write_addr;
            bus.be_wdata = bus.write_wdata;
            bus.be_wstrb = bus.write_wstrb;
            if (bus.be_ready) begin
               bus.write_ready = 1'b1;
               state_d         = S_IDLE;
            end
         end
         S_RD: begin
            bus.be_valid  = 1'b1;
            bus.be_addr   = rd_addr;
            bus.replace   = 1'b1;
            bus.read_addr = beat_q;
            if (bus.be_ready) begin
               bus.read_valid = 1'b1;
               bus.read_rdata = bus.be_rdata;
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = S_IDLE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end
endmodule

// File: tb/tb_iob_cache_back_end_arb.sv
// tb_iob_cache_back_end_arb
// Directed bench: dut_a has writes winning ties, dut_b has replacement winning.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_iob_cache_back_end_arb;
   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   n_wr;
   logic got_rd;

   always #5 clk = ~clk;

   iob_cache_back_end_arb_if #(.BE_ADDR_W(32), .BE_DATA_W(32), .LINE2BE_W(2)) if_a ();
   iob_cache_back_end_arb_if #(.BE_ADDR_W(32), .BE_DATA_W(32), .LINE2BE_W(2)) if_b ();

   iob_cache_back_end_arb #(
      .BE_ADDR_W(32), .BE_DATA_W(32), .LINE2BE_W(2), .WRITE_FIRST(1), .STARVE_W(3)
   ) dut_a (.clk_i(clk), .reset(rst), .bus(if_a));

   iob_cache_back_end_arb #(
      .BE_ADDR_W(32), .BE_DATA_W(32), .LINE2BE_W(2), .WRITE_FIRST(0), .STARVE_W(3)
   ) dut_b (.clk_i(clk), .reset(rst), .bus(if_b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      if_a.write_valid = 0; if_a.write_addr = 0; if_a.write_wdata = 0; if_a.write_wstrb = 0;
      if_a.replace_valid = 0; if_a.replace_addr = 0; if_a.be_rdata = 0; if_a.be_ready = 0;
      if_b.write_valid = 0; if_b.write_addr = 0; if_b.write_wdata = 0; if_b.write_wstrb = 0;
      if_b.replace_valid = 0; if_b.replace_addr = 0; if_b.be_rdata = 0; if_b.be_ready = 0;

      // Reset state
      tick(); tick();
      samp();
      chk("rst_be_valid",    if_a.be_valid, 0);
      chk("rst_be_addr",     if_a.be_addr, 0);
      chk("rst_be_wstrb",    if_a.be_wstrb, 0);
      chk("rst_write_ready", if_a.write_ready, 0);
      chk("rst_replace",     if_a.replace, 0);
      chk("rst_read_valid",  if_a.read_valid, 0);
      chk("rst_read_addr",   if_a.read_addr, 0);
      chk("rst_b_be_valid",  if_b.be_valid, 0);
      tick(); rst = 1'b0;

      // Lone write to 0x104, be_ready two cycles after the request
      tick();
      if_a.write_valid = 1; if_a.write_addr = 32'h104; if_a.write_wdata = 32'hDEAD_BEEF; if_a.write_wstrb = 4'hF;
      samp();
      chk("t1_idle_be_valid", if_a.be_valid, 0);
      tick(); samp();
      chk("t1_be_valid",    if_a.be_valid, 1);
      chk("t1_be_addr",     if_a.be_addr, 32'h104);
      chk("t1_be_wstrb",    if_a.be_wstrb, 4'hF);
      chk("t1_be_wdata",    if_a.be_wdata, 32'hDEAD_BEEF);
      chk("t1_wready_wait", if_a.write_ready, 0);
      tick(); if_a.be_ready = 1; samp();
      chk("t1_wready",      if_a.write_ready, 1);
      tick(); if_a.be_ready = 0; if_a.write_valid = 0; samp();
      chk("t1_done_valid",  if_a.be_valid, 0);
      chk("t1_done_wready", if_a.write_ready, 0);
      tick(); samp();
      chk("t1_no_reissue",  if_a.be_valid, 0);

      // Lone replace of line 0x10, be_ready every cycle
      tick();
      if_a.replace_valid = 1; if_a.replace_addr = 'h10; if_a.be_ready = 1;
      samp();
      chk("t2_idle_read_valid", if_a.read_valid, 0);
      chk("t2_idle_replace",    if_a.replace, 0);
      for (int i = 0; i < 4; i++) begin
         tick(); if_a.be_rdata = 32'hA0A0_0000 + 32'(i); samp();
         chk("t2_be_addr",     if_a.be_addr, 32'h100 + 32'(4 * i));
         chk("t2_read_addr",   if_a.read_addr, i);
         chk("t2_read_valid",  if_a.read_valid, 1);
         chk("t2_replace",     if_a.replace, 1);
         chk("t2_be_wstrb",    if_a.be_wstrb, 0);
         chk("t2_read_rdata",  if_a.read_rdata, 32'hA0A0_0000 + 32'(i));
      end
      tick(); if_a.replace_valid = 0; if_a.be_ready = 0; samp();
      chk("t2_done_replace",    if_a.replace, 0);
      chk("t2_done_be_valid",   if_a.be_valid, 0);
      chk("t2_done_read_valid", if_a.read_valid, 0);

      // Hazard: write to 0x108 and replace of line 0x10 together, replace-first DUT
      tick();
      if_b.write_valid = 1; if_b.write_addr = 32'h108; if_b.write_wdata = 32'h1234_5678; if_b.write_wstrb = 4'h3;
      if_b.replace_valid = 1; if_b.replace_addr = 'h10; if_b.be_ready = 1;
      samp();
      chk("t3_idle_be_valid", if_b.be_valid, 0);
      tick(); samp();
      chk("t3_wr_addr",    if_b.be_addr, 32'h108);
      chk("t3_wr_wstrb",   if_b.be_wstrb, 4'h3);
      chk("t3_wr_ready",   if_b.write_ready, 1);
      chk("t3_wr_replace", if_b.replace, 0);
      tick(); if_b.write_valid = 0; samp();
      chk("t3_turn_valid",   if_b.be_valid, 0);
      chk("t3_turn_replace", if_b.replace, 0);
      for (int i = 0; i < 4; i++) begin
         tick(); samp();
         chk("t3_rd_addr",    if_b.be_addr, 32'h100 + 32'(4 * i));
         chk("t3_rd_replace", if_b.replace, 1);
      end
      tick(); if_b.replace_valid = 0; samp();
      chk("t3_done_valid", if_b.be_valid, 0);

      // No hazard, replace-first DUT: burst goes before the write to 0x200
      tick();
      if_b.write_valid = 1; if_b.write_addr = 32'h200; if_b.write_wstrb = 4'hF;
      if_b.replace_valid = 1; if_b.replace_addr = 'h10;
      samp();
      chk("t3b_idle_valid", if_b.be_valid, 0);
      tick(); samp();
      chk("t3b_rd_first",   if_b.replace, 1);
      chk("t3b_rd_wstrb",   if_b.be_wstrb, 0);
      chk("t3b_rd_addr",    if_b.be_addr, 32'h100);
      tick(); tick(); tick();
      tick(); if_b.replace_valid = 0; samp();
      chk("t3b_turn_valid", if_b.be_valid, 0);
      tick(); samp();
      chk("t3b_wr_addr",    if_b.be_addr, 32'h200);
      chk("t3b_wr_ready",   if_b.write_ready, 1);
      tick(); if_b.write_valid = 0; if_b.be_ready = 0; samp();
      chk("t3b_done_valid", if_b.be_valid, 0);

      // Starvation bound: continuous writes with a pending replace, writes win ties
      tick();
      if_a.write_valid = 1; if_a.write_addr = 32'h1000; if_a.write_wdata = 32'h5555_AAAA; if_a.write_wstrb = 4'hF;
      if_a.replace_valid = 1; if_a.replace_addr = 'h10; if_a.be_ready = 1;
      n_wr = 0; got_rd = 0;
      for (int c = 0; c < 60 && !got_rd; c++) begin
         samp();
         if (if_a.replace) got_rd = 1;
         else begin
            if (if_a.write_ready) n_wr++;
            tick();
            if_a.write_addr = 32'h1000 + 32'(4 * n_wr);
         end
      end
      chk("t4_rd_granted",       got_rd, 1);
      chk("t4_writes_before_rd", n_wr, 7);
      chk("t4_rd_addr",          if_a.be_addr, 32'h100);
      tick(); tick(); tick();
      tick(); if_a.write_valid = 0; if_a.replace_valid = 0; if_a.be_ready = 0; samp();
      chk("t4_done_valid", if_a.be_valid, 0);

      // Reset on beat 2 of a burst, then re-issue
      tick();
      if_a.replace_valid = 1; if_a.replace_addr = 'h20; if_a.be_ready = 1;
      samp();
      tick(); samp();
      tick(); samp();
      tick(); rst = 1'b1; samp();
      chk("t5_beat2_read_addr", if_a.read_addr, 2);
      chk("t5_beat2_be_addr",   if_a.be_addr, 32'h208);
      tick(); rst = 1'b0; samp();
      chk("t5_rst_be_valid",   if_a.be_valid, 0);
      chk("t5_rst_replace",    if_a.replace, 0);
      chk("t5_rst_read_valid", if_a.read_valid, 0);
      chk("t5_rst_read_addr",  if_a.read_addr, 0);
      chk("t5_rst_be_addr",    if_a.be_addr, 0);
      tick(); samp();
      chk("t5_restart_addr",      if_a.be_addr, 32'h200);
      chk("t5_restart_read_addr", if_a.read_addr, 0);
      chk("t5_restart_rvalid",    if_a.read_valid, 1);
      tick(); tick(); tick();
      tick(); if_a.replace_valid = 0; if_a.be_ready = 0; samp();
      chk("t5_done_valid", if_a.be_valid, 0);

      // be_ready stalled 5 cycles on beat 2
      tick();
      if_a.replace_valid = 1; if_a.replace_addr = 'h30; if_a.be_ready = 1;
      samp();
      tick(); samp();
      chk("t6_beat0_addr", if_a.be_addr, 32'h300);
      tick(); samp();
      tick(); if_a.be_ready = 0;
      for (int k = 0; k < 5; k++) begin
         samp();
         chk("t6_stall_valid",     if_a.be_valid, 1);
         chk("t6_stall_addr",      if_a.be_addr, 32'h308);
         chk("t6_stall_read_addr", if_a.read_addr, 2);
         chk("t6_stall_rvalid",    if_a.read_valid, 0);
         tick();
      end
      if_a.be_ready = 1; samp();
      chk("t6_resume_rvalid", if_a.read_valid, 1);
      chk("t6_resume_raddr",  if_a.read_addr, 2);
      tick(); samp();
      chk("t6_last_raddr", if_a.read_addr, 3);
      chk("t6_last_addr",  if_a.be_addr, 32'h30C);
      tick(); if_a.replace_valid = 0; if_a.be_ready = 0; samp();
      chk("t6_done_valid", if_a.be_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
